// File: rtl/psum_pool_buffer.sv
// Partial-sum buffer: channel accumulation into two row buffers, 2x2 max
// pooling, ReLU, round-half-to-even requantisation and saturation; FC mode.
module psum_pool_buffer #(
    parameter int PSUM_W   = 24,
    parameter int OUT_W    = 8,
    parameter int MAX_COLS = 96,
    parameter int COL_W    = 7,
    parameter int CH_W     = 4,
    parameter int SH_W     = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     cfg_mode,
    input  logic [COL_W-1:0]         cfg_cols,
    input  logic [CH_W-1:0]          cfg_ch_last,
    input  logic [SH_W-1:0]          cfg_shift,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PSUM_W-1:0] data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         data_out,
    output logic                     data_last,
    output logic                     busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ROW0, S_ROW1, S_POOL, S_FC_ACC, S_QUANT, S_OUT
    } state_e;

    state_e state_q, state_d;

    logic                     mode_q;
    logic [COL_W-1:0]         cols_q;
    logic [CH_W-1:0]          chl_q;
    logic [SH_W-1:0]          sh_q;
    logic [COL_W-1:0]         col_q;
    logic [COL_W-1:0]         p_q;
    logic [CH_W-1:0]          ch_q;
    logic signed [PSUM_W-1:0] row0_q [MAX_COLS];
    logic signed [PSUM_W-1:0] row1_q [MAX_COLS];
    logic signed [PSUM_W-1:0] acc_q;
    logic signed [PSUM_W-1:0] mp_q;
    logic [OUT_W-1:0]         dout_q;
    logic                     last_q;

    logic                     xfer;
    logic                     col_end;
    logic                     ch_end;
    logic                     pool_done;
    logic [COL_W-1:0]         pp1;

    logic signed [PSUM_W-1:0] qx;
    logic [PSUM_W-1:0]        qv;
    logic [PSUM_W-1:0]        qs;
    logic [PSUM_W-1:0]        qmask;
    logic [PSUM_W-1:0]        qrem;
    logic [PSUM_W-1:0]        qhalf;
    logic                     qrnd;
    logic [PSUM_W-1:0]        qr;
    logic [OUT_W-1:0]         qsat;

    function automatic logic signed [PSUM_W-1:0] smax(
        input logic signed [PSUM_W-1:0] a,
        input logic signed [PSUM_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    assign xfer      = in_valid && in_ready;
    assign col_end   = (col_q == cols_q);
    assign ch_end    = (ch_q == chl_q);
    assign pool_done = (p_q >= cols_q);
    assign pp1       = p_q + COL_W'(1);
    assign data_out  = dout_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != S_IDLE);
        data_last = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = cfg_mode ? S_FC_ACC : S_ROW0;
            end
            S_ROW0: begin
                in_ready = 1'b1;
                if (xfer && col_end) state_d = S_ROW1;
            end
            S_ROW1: begin
                in_ready = 1'b1;
                if (xfer && col_end) begin
                    if (!ch_end)              state_d = S_ROW0;
                    else if (cols_q == '0)    state_d = S_IDLE;
                    else                      state_d = S_POOL;
                end
            end
            S_POOL: state_d = S_QUANT;
            S_FC_ACC: begin
                in_ready = 1'b1;
                if (xfer && ch_end) state_d = S_QUANT;
            end
            S_QUANT: state_d = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                data_last = last_q;
                if (out_ready) state_d = (mode_q || pool_done) ? S_IDLE : S_POOL;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ReLU, round-half-to-even right shift, saturation
    always_comb begin
        qx    = mode_q ? acc_q : mp_q;
        qv    = qx[PSUM_W-1] ? '0 : qx;
        qs    = qv >> sh_q;
        qmask = (PSUM_W'(1) << sh_q) - PSUM_W'(1);
        qrem  = qv & qmask;
        qhalf = PSUM_W'(1) << (sh_q - SH_W'(1));
        qrnd  = (sh_q != '0) && ((qrem > qhalf) || ((qrem == qhalf) && qs[0]));
        qr    = qs + PSUM_W'(qrnd);
        qsat  = (|qr[PSUM_W-1:OUT_W]) ? '1 : qr[OUT_W-1:0];
    end

    // Datapath: config latch, accumulation, pooling, result register
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b0;
            cols_q <= '0;
            chl_q  <= '0;
            sh_q   <= '0;
            col_q  <= '0;
            p_q    <= '0;
            ch_q   <= '0;
            acc_q  <= '0;
            mp_q   <= '0;
            dout_q <= '0;
            last_q <= 1'b0;
            for (int i = 0; i < MAX_COLS; i++) begin
                row0_q[i] <= '0;
                row1_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    col_q <= '0;
                    p_q   <= '0;
                    ch_q  <= '0;
                    acc_q <= '0;
                    for (int i = 0; i < MAX_COLS; i++) begin
                        row0_q[i] <= '0;
                        row1_q[i] <= '0;
                    end
                    if (start) begin
                        mode_q <= cfg_mode;
                        cols_q <= cfg_cols;
                        chl_q  <= cfg_ch_last;
                        sh_q   <= cfg_shift;
                    end
                end
                S_ROW0: begin
                    if (xfer) begin
                        row0_q[col_q] <= row0_q[col_q] + data_in;
                        col_q <= col_end ? '0 : col_q + COL_W'(1);
                    end
                end
                S_ROW1: begin
                    if (xfer) begin
                        row1_q[col_q] <= row1_q[col_q] + data_in;
                        col_q <= col_end ? '0 : col_q + COL_W'(1);
                        if (col_end && !ch_end) ch_q <= ch_q + CH_W'(1);
                    end
                end
                S_POOL: begin
                    mp_q <= smax(smax(row0_q[p_q], row0_q[pp1]),
                                 smax(row1_q[p_q], row1_q[pp1]));
                    p_q  <= p_q + COL_W'(2);
                end
                S_FC_ACC: begin
                    if (xfer) begin
                        acc_q <= acc_q + data_in;
                        ch_q  <= ch_q + CH_W'(1);
                    end
                end
                S_QUANT: begin
                    dout_q <= qsat;
                    last_q <= mode_q || pool_done;
                end
                S_OUT: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_pool_buffer.sv
// Randomised and directed bench for psum_pool_buffer against a
// behavioural job model (sums, pooling and requantisation in plain integers).
module tb_psum_pool_buffer;

    localparam int MAX_COLS = 96;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              cfg_mode;
    logic [6:0]        cfg_cols;
    logic [3:0]        cfg_ch_last;
    logic [4:0]        cfg_shift;
    logic              in_valid;
    logic              in_ready;
    logic signed [23:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        data_out;
    logic              data_last;
    logic              busy;

    typedef struct {
        int d;
        bit l;
    } exp_t;

    exp_t exp_q[$];
    int   stim[$];
    int   tests = 0;
    int   fails = 0;
    bit   bp_hold = 1'b0;
    bit   have_prev = 1'b0;
    int   prev_d;
    bit   prev_l;
    exp_t ce;

    psum_pool_buffer dut (
        .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode),
        .cfg_cols(cfg_cols), .cfg_ch_last(cfg_ch_last),
        .cfg_shift(cfg_shift), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .data_last(data_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint wrap24(input longint x);
        longint t;
        t = x & 64'hFFFFFF;
        if (t >= 64'd8388608) t = t - 64'd16777216;
        return t;
    endfunction

    function automatic int requant(input longint x, input int sh);
        longint v, den, q, rem;
        v   = (x < 0) ? 0 : x;
        den = longint'(1) << sh;
        q   = v / den;
        rem = v - q * den;
        if (sh > 0 && ((2 * rem > den) || (2 * rem == den && (q % 2) == 1)))
            q = q + 1;
        return (q > 255) ? 255 : int'(q);
    endfunction

    function automatic longint max2(input longint a, input longint b);
        return (a > b) ? a : b;
    endfunction

    // Expected outputs of one job from the stimulus list
    task automatic model_job(input bit mode, input int cols, input int chl, input int sh);
        longint r0[MAX_COLS];
        longint r1[MAX_COLS];
        longint acc;
        longint m;
        int k;
        exp_t e;
        k = 0;
        acc = 0;
        foreach (r0[i]) begin
            r0[i] = 0;
            r1[i] = 0;
        end
        if (mode) begin
            for (int i = 0; i <= chl; i++) acc += stim[i];
            e.d = requant(wrap24(acc), sh);
            e.l = 1'b1;
            exp_q.push_back(e);
        end else begin
            for (int c = 0; c <= chl; c++) begin
                for (int i = 0; i <= cols; i++) r0[i] += stim[k++];
                for (int i = 0; i <= cols; i++) r1[i] += stim[k++];
            end
            for (int p = 0; p + 1 <= cols; p += 2) begin
                m = max2(max2(wrap24(r0[p]), wrap24(r0[p+1])),
                         max2(wrap24(r1[p]), wrap24(r1[p+1])));
                e.d = requant(m, sh);
                e.l = (p + 3 > cols);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send(input int v);
        int n;
        n = 0;
        data_in  = 24'(v);
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 1000) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            data_in = 24'($urandom);
            n++;
        end
        if (busy) chk("idle_timeout", 0, 1);
        in_valid = 1'b0;
        chk("out_count_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_job(input bit mode, input int cols, input int chl,
                           input int sh, input bit lat_chk, input bit bp_chk,
                           input bit extra_start);
        int n;
        model_job(mode, cols, chl, sh);
        bp_hold     = bp_chk;
        cfg_mode    = mode;
        cfg_cols    = 7'(cols);
        cfg_ch_last = 4'(chl);
        cfg_shift   = 5'(sh);
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        foreach (stim[i]) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(stim[i]);
            if (i == 0 && extra_start) begin
                cfg_mode = ~mode;
                cfg_cols = 7'($urandom_range(0, 95));
                start    = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        in_valid = 1'b1;
        data_in  = 24'($urandom);
        if (lat_chk) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid && n < 10);
            chk("latency", n, 3);
        end
        if (bp_chk) begin
            n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("bp_reach_out", out_valid, 1);
            repeat (5) begin
                @(negedge clk);
                chk("bp_valid_held", out_valid, 1);
                chk("bp_busy_held", busy, 1);
            end
            bp_hold = 1'b0;
        end
        wait_idle();
        stim.delete();
    endtask

    task automatic load_t1();
        stim = '{1, 5, 2, 0, 3, 4, 9, 7};
    endtask

    function automatic int rand_psum();
        int v;
        if ($urandom_range(0, 9) == 0) begin
            v = int'($urandom) & 32'hFFFFFF;
            if (v >= 8388608) v = v - 16777216;
        end else begin
            v = int'($urandom_range(0, 6000)) - 2000;
        end
        return v;
    endfunction

    // Downstream ready, randomly throttled unless held low
    always @(posedge clk) begin
        #1;
        out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Output checker: every handshake against the model, hold while stalled
    always @(negedge clk) begin
        if (rst) begin
            have_prev = 1'b0;
        end else if (out_valid) begin
            if (have_prev) begin
                chk("hold_data", data_out, prev_d);
                chk("hold_last", data_last, prev_l);
            end
            if (out_ready) begin
                have_prev = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("extra_output", 1, 0);
                end else begin
                    ce = exp_q.pop_front();
                    chk("data_out", data_out, ce.d);
                    chk("data_last", data_last, ce.l);
                end
            end else begin
                have_prev = 1'b1;
                prev_d    = data_out;
                prev_l    = data_last;
            end
        end else begin
            if (have_prev) chk("valid_dropped", 0, 1);
            have_prev = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!rst && start && !busy)
            assert (cfg_cols < MAX_COLS)
            else $error("illegal cfg_cols %0d", cfg_cols);
    end

    initial begin
        int mode, cols, chl, sh, n;
        rst         = 1'b1;
        start       = 1'b0;
        cfg_mode    = 1'b0;
        cfg_cols    = '0;
        cfg_ch_last = '0;
        cfg_shift   = '0;
        in_valid    = 1'b0;
        data_in     = '0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_data_last", data_last, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        chk("model_rnd_6", requant(6, 2), 2);
        chk("model_rnd_10", requant(10, 2), 2);
        chk("model_rnd_11", requant(11, 2), 3);
        chk("model_relu", requant(-40, 2), 0);
        chk("model_sat", requant(300, 0), 255);
        chk("model_wrap", requant(wrap24(2 * 8388607), 0), 0);

        load_t1();
        model_job(0, 3, 0, 0);
        chk("model_t1_n", exp_q.size(), 2);
        chk("model_t1_a", exp_q[0].d, 5);
        chk("model_t1_b", exp_q[1].d, 9);
        chk("model_t1_last", exp_q[1].l, 1);
        exp_q.delete();
        run_job(0, 3, 0, 0, 1, 0, 0);

        for (int i = 0; i < 12; i++) stim.push_back(100);
        run_job(0, 1, 2, 2, 0, 1, 0);

        stim = '{6};
        run_job(1, 0, 0, 2, 0, 0, 0);
        stim = '{10};
        run_job(1, 0, 0, 2, 0, 0, 0);
        stim = '{11};
        run_job(1, 0, 0, 2, 0, 0, 0);
        stim = '{-40};
        run_job(1, 0, 0, 2, 0, 0, 0);
        stim = '{300};
        run_job(1, 0, 0, 0, 0, 1, 0);
        stim = '{8388607, 8388607};
        run_job(1, 0, 1, 0, 0, 0, 0);

        cfg_mode    = 1'b0;
        cfg_cols    = 7'd3;
        cfg_ch_last = 4'd0;
        cfg_shift   = 5'd0;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) send(50);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_in_ready", in_ready, 0);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("rstmid_no_output", n, 0);
        load_t1();
        run_job(0, 3, 0, 0, 0, 0, 0);

        for (int j = 0; j < 40; j++) begin
            mode = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) begin
                cols = $urandom_range(0, MAX_COLS - 1);
                chl  = $urandom_range(0, 3);
            end else begin
                cols = $urandom_range(0, 12);
                chl  = $urandom_range(0, 15);
            end
            sh = $urandom_range(0, 6);
            n  = mode ? chl + 1 : 2 * (cols + 1) * (chl + 1);
            for (int i = 0; i < n; i++) stim.push_back(rand_psum());
            run_job(mode[0], cols, chl, sh, 0, ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/psum_pool_buffer.md
Name: psum_pool_buffer

Overview:
Parametrised successor to the fixed-geometry partial-sum buffer in the EPU. It accumulates signed partial sums over a run-time number of input channels into two row buffers, then applies 2x2 max pooling, ReLU, round-half-to-even requantisation and saturation. Results stream out on a valid/ready handshake. An FC mode accumulates a run-time number of partial sums into a single result. It sits between the PE array output and the activation SRAM writer.

Parameters:
PSUM_W, 24, partial-sum width, two's complement
OUT_W, 8, output activation width, unsigned
MAX_COLS, 96, row-buffer depth (max input row length)
COL_W, 7, column counter width, must satisfy 2^COL_W >= MAX_COLS
CH_W, 4, channel counter width
SH_W, 5, requant shift field width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; latches cfg_* when in IDLE
cfg_mode  in  1  0 = conv+pool, 1 = FC
cfg_cols  in  COL_W  input row length minus 1
cfg_ch_last  in  CH_W  channel count minus 1 (FC: number of psums minus 1)
cfg_shift  in  SH_W  requant right shift, 0..PSUM_W-OUT_W
in_valid  in  1  data_in valid
in_ready  out  1  block accepts data_in this cycle
data_in  in  PSUM_W  signed partial sum
out_valid  out  1  data_out valid
out_ready  in  1  downstream accepts data_out
data_out  out  OUT_W  requantised activation
data_last  out  1  high with the final output of the job
busy  out  1  high in every state except IDLE

Behaviour:
- Reset is synchronous and active-high on clk. Requirement: cur_state=IDLE; all counters 0; both row buffers and the FC accumulator 0; out_valid=0, data_out=0, data_last=0, in_ready=0, busy=0.
- Reset asserted mid-job aborts the job: no further outputs, and state is IDLE on the next cycle.
- Input transfer occurs on in_valid && in_ready. in_ready=1 only in ROW0, ROW1 and FC_ACC.
- States:
  - IDLE: clears buffers. On start: latch cfg_*, then go to FC_ACC (mode 1) or ROW0. start outside IDLE is ignored.
  - ROW0: each transfer does row0[col] += data_in, wrapping modulo 2^PSUM_W. At col==cfg_cols: col<=0, go to ROW1.
  - ROW1: same on row1. At col==cfg_cols: if ch==cfg_ch_last, go to POOL; else ch++ and go to ROW0.
  - POOL (1 cycle): mp = signed max of row0[p], row0[p+1], row1[p], row1[p+1]; p += 2.
  - FC_ACC: acc += data_in per transfer. After the (cfg_ch_last+1)-th transfer, go to QUANT.
  - QUANT (1 cycle): v = max(x, 0), where x = mp or acc. q = v >> cfg_shift, rounded half-to-even on the discarded bits (no rounding when cfg_shift==0). data_out = min(q, 2^OUT_W-1). Go to OUT.
  - OUT: out_valid=1. data_out and data_last stay stable until out_ready.
    - On handshake in conv mode: if p > cfg_cols-1, go to IDLE; else go to POOL.
    - On handshake in FC mode: go to IDLE.
- data_last=1 in OUT for the final pooled output, or for the FC output.
- Pooled outputs per job = (cfg_cols+1)/2, floored. With odd row length the last column is accumulated but never pooled.
- Latency: last conv input to first output valid = 3 cycles (ROW1 exit to POOL, QUANT, OUT). Between outputs with out_ready held high = 3 cycles.
- cfg_cols >= MAX_COLS is illegal and behaviour is undefined. The verification environment flags it with an assertion.
- in_valid in a non-accepting state is ignored: no accumulation and no counter change.

Test Plan:
- Conv, cfg_cols=3, cfg_ch_last=0, cfg_shift=0; row0=1,5,2,0 and row1=3,4,9,7 -> outputs 5, then 9; data_last on 9; exactly 2 outputs.
- Channel accumulation, cfg_cols=1, cfg_ch_last=2; every psum=100 on all 3 channels, cfg_shift=2 -> single output 75 (300>>2), data_last=1.
- Rounding, FC mode, cfg_ch_last=0, cfg_shift=2 -> inputs 6 (1.5) gives 2, 10 (2.5) gives 2, 11 gives 3, -40 gives 0 (ReLU).
- Saturation, FC mode, cfg_shift=0, input 300 -> data_out 255. Wrap check: two psums of 2^23-1 in FC mode give a negative sum -> 0.
- Backpressure: hold out_ready=0 for 5 cycles in OUT -> data_out and data_last stable, no state advance. Also drive in_valid during OUT -> ignored.
- Reset mid-job: assert rst during ROW1 -> IDLE next cycle, out_valid=0. A fresh job afterwards produces correct results with no stale accumulation.
